// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : piso_serializer
// Brief    : Valid/ready parallel-in serial-out word serializer with framing
//            strobes and an optional inter-word idle gap.
//            Optional even-parity trailer bit: define PISO_PARITY_EN.
// Revision : 1.0  initial release
// ============================================================================
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pi_data,
  input  logic             pi_valid,
  output logic             pi_ready,
  output logic             so,
  output logic             so_valid,
  output logic             so_first,
  output logic             so_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef PISO_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam logic [CW-1:0] LAST_IDX  = CW'(NBITS - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LAST  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       gap_q, gap_d;
  logic             so_q, so_d;
  logic             so_valid_q, so_valid_d;
  logic             so_first_q, so_first_d;
  logic             so_last_q, so_last_d;
  logic             ready_q, ready_d;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic             handshake;
  logic             load;
  logic [CW-1:0]    cnt_inc;
  logic             load_bit, shift_bit;
  logic [WIDTH-1:0] load_rest, shift_rest;

  assign handshake = pi_valid & ready_q;
  assign cnt_inc   = cnt_q + CW'(1);

  // The register holds the bits not yet on so; the outgoing bit sits in so_q.
  assign load_bit   = LSB_FIRST ? pi_data[0] : pi_data[WIDTH-1];
  assign load_rest  = LSB_FIRST ? {1'b0, pi_data[WIDTH-1:1]} : {pi_data[WIDTH-2:0], 1'b0};
  assign shift_bit  = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
  assign shift_rest = LSB_FIRST ? {1'b0, shreg_q[WIDTH-1:1]} : {shreg_q[WIDTH-2:0], 1'b0};

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    so_d       = 1'b0;
    so_valid_d = 1'b0;
    so_first_d = 1'b0;
    so_last_d  = 1'b0;
    ready_d    = 1'b0;
    load       = 1'b0;
`ifdef PISO_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (handshake) load = 1'b1;
      end
      S_SHIFT: begin
        if (cnt_q == LAST_IDX) begin
          if (GAP > 0) begin
            state_d = S_GAP;
            gap_d   = 4'd0;
          end else if (handshake) begin
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d      = cnt_inc;
          so_valid_d = 1'b1;
          so_last_d  = (cnt_inc == LAST_IDX);
          ready_d    = (cnt_inc == LAST_IDX) && (GAP == 0);
`ifdef PISO_PARITY_EN
          if (cnt_q == DATA_LAST) begin
            so_d = parity_q;
          end else begin
            so_d    = shift_bit;
            shreg_d = shift_rest;
          end
`else
          so_d    = shift_bit;
          shreg_d = shift_rest;
`endif
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Acceptance overrides the per-state defaults, giving zero-bubble reloads.
    if (load) begin
      state_d    = S_SHIFT;
      cnt_d      = '0;
      shreg_d    = load_rest;
      so_d       = load_bit;
      so_valid_d = 1'b1;
      so_first_d = 1'b1;
      so_last_d  = (LAST_IDX == '0);
      ready_d    = 1'b0;
`ifdef PISO_PARITY_EN
      parity_d   = ^pi_data;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      so_q       <= 1'b0;
      so_valid_q <= 1'b0;
      so_first_q <= 1'b0;
      so_last_q  <= 1'b0;
      ready_q    <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      so_q       <= so_d;
      so_valid_q <= so_valid_d;
      so_first_q <= so_first_d;
      so_last_q  <= so_last_d;
      ready_q    <= ready_d;
`ifdef PISO_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign pi_ready = ready_q;
  assign so       = so_q;
  assign so_valid = so_valid_q;
  assign so_first = so_first_q;
  assign so_last  = so_last_q;
  assign busy     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_serializer
// Brief    : Directed bench for piso_serializer (three parameterisations).
//            Expectations follow PISO_PARITY_EN when it is defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int L = 4 + PAR;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] v = '0;
  logic [3:0] d [3];
  logic [2:0] so, sov, fst, lst, rdy, bsy;
  logic [3:0] po = '0;

  int total = 0;
  int pass  = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1), .GAP(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .pi_data(d[0]), .pi_valid(v[0]), .pi_ready(rdy[0]),
    .so(so[0]), .so_valid(sov[0]), .so_first(fst[0]), .so_last(lst[0]), .busy(bsy[0]));

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1), .GAP(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .pi_data(d[1]), .pi_valid(v[1]), .pi_ready(rdy[1]),
    .so(so[1]), .so_valid(sov[1]), .so_first(fst[1]), .so_last(lst[1]), .busy(bsy[1]));

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0), .GAP(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .pi_data(d[2]), .pi_valid(v[2]), .pi_ready(rdy[2]),
    .so(so[2]), .so_valid(sov[2]), .so_first(fst[2]), .so_last(lst[2]), .busy(bsy[2]));

  // Observation vector: {so, so_valid, so_first, so_last, pi_ready, busy}
  function automatic logic [5:0] obs(input int i);
    return {so[i], sov[i], fst[i], lst[i], rdy[i], bsy[i]};
  endfunction

  function automatic logic bitk(input logic [3:0] w, input int k, input bit lsb);
    if (k >= 4) return ^w;
    return lsb ? w[k] : w[3-k];
  endfunction

  task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  // Caller presents the word so that the next edge accepts it.
  task automatic check_word(input int i, input logic [3:0] w, input bit lsb, input bit gap,
                            input bit keep, input logic [3:0] next_d, input string nm);
    logic [5:0] e;
    for (int k = 0; k < L; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        if (!keep) v[i] = 1'b0;
        d[i] = next_d;
      end
      e = {bitk(w, k, lsb), 1'b1, (k == 0), (k == L-1), (k == L-1) && !gap, 1'b1};
      chk($sformatf("%s_b%0d", nm, k), obs(i), e);
      if (i == 2 && k < 4) po = {so[2], po[3:1]};
    end
  endtask

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic vv, input logic [3:0] dd, input logic [5:0] ee);
    vec_t r;
    r.v = vv; r.d = dd; r.exp = ee;
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) d[i] = 4'd0;

`ifdef PISO_PARITY_EN
    tbl.push_back(mk(1'b0, 4'b0000, 6'b000010));
    tbl.push_back(mk(1'b1, 4'b1011, 6'b111001));
    tbl.push_back(mk(1'b1, 4'b0110, 6'b110001));
    tbl.push_back(mk(1'b1, 4'b0110, 6'b010001));
    tbl.push_back(mk(1'b1, 4'b0110, 6'b110001));
    tbl.push_back(mk(1'b1, 4'b0110, 6'b110111));
    tbl.push_back(mk(1'b1, 4'b0110, 6'b011001));
    tbl.push_back(mk(1'b0, 4'b0000, 6'b110001));
    tbl.push_back(mk(1'b0, 4'b0000, 6'b110001));
    tbl.push_back(mk(1'b0, 4'b0000, 6'b010001));
    tbl.push_back(mk(1'b0, 4'b0000, 6'b010111));
    tbl.push_back(mk(1'b0, 4'b0000, 6'b000010));
    tbl.push_back(mk(1'b1, 4'b0101, 6'b111001));
    tbl.push_back(mk(1'b0, 4'b0000, 6'b010001));
    tbl.push_back(mk(1'b0, 4'b0000, 6'b110001));
    tbl.push_back(mk(1'b0, 4'b0000, 6'b010001));
    tbl.push_back(mk(1'b0, 4'b0000, 6'b010111));
    tbl.push_back(mk(1'b0, 4'b0000, 6'b000010));
`else
    tbl.push_back(mk(1'b0, 4'b0000, 6'b000010));
    tbl.push_back(mk(1'b1, 4'b1011, 6'b111001));
    tbl.push_back(mk(1'b1, 4'b0110, 6'b110001));
    tbl.push_back(mk(1'b1, 4'b0110, 6'b010001));
    tbl.push_back(mk(1'b1, 4'b0110, 6'b110111));
    tbl.push_back(mk(1'b1, 4'b0110, 6'b011001));
    tbl.push_back(mk(1'b0, 4'b0000, 6'b110001));
    tbl.push_back(mk(1'b0, 4'b0000, 6'b110001));
    tbl.push_back(mk(1'b0, 4'b0000, 6'b010111));
    tbl.push_back(mk(1'b0, 4'b0000, 6'b000010));
    tbl.push_back(mk(1'b1, 4'b0101, 6'b111001));
    tbl.push_back(mk(1'b0, 4'b0000, 6'b010001));
    tbl.push_back(mk(1'b0, 4'b0000, 6'b110001));
    tbl.push_back(mk(1'b0, 4'b0000, 6'b010111));
    tbl.push_back(mk(1'b0, 4'b0000, 6'b000010));
`endif

    // Reset state, with a clock edge inside reset
    #12;
    for (int i = 0; i < 3; i++) chk($sformatf("reset_dut%0d", i), obs(i), 6'b000000);
    @(negedge clk);
    rst_n = 1'b1;

    // Single word then back-to-back words on the GAP=0, LSB-first instance
    for (int i = 0; i < tbl.size(); i++) begin
      v[0] = tbl[i].v;
      d[0] = tbl[i].d;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), obs(0), tbl[i].exp);
    end
    v[0] = 1'b0;

    // GAP=2 with pi_valid held high across the gap
    v[1] = 1'b1;
    d[1] = 4'b1001;
    check_word(1, 4'b1001, 1'b1, 1'b1, 1'b1, 4'b0011, "gap_w0");
    for (int g = 0; g < 2; g++) begin
      @(posedge clk); #1;
      chk($sformatf("gap_idle%0d", g), obs(1), 6'b000001);
    end
    @(posedge clk); #1;
    chk("gap_ready", obs(1), 6'b000010);
    check_word(1, 4'b0011, 1'b1, 1'b1, 1'b0, 4'b0000, "gap_w1");
    @(posedge clk); #1;
    chk("gap_after", obs(1), 6'b000001);

    // MSB-first word into a modelled MSB-in SIPO
    v[2] = 1'b1;
    d[2] = 4'b1011;
    check_word(2, 4'b1011, 1'b0, 1'b0, 1'b0, 4'b0000, "msb");
    chk("msb_sipo_po", {2'b00, po}, 6'b001101);
    @(posedge clk); #1;
    chk("msb_idle", obs(2), 6'b000010);

    // Asynchronous reset in the middle of a word
    v[0] = 1'b1;
    d[0] = 4'b1111;
    @(posedge clk); #1;
    v[0] = 1'b0;
    chk("rst_mid_b0", obs(0), 6'b111001);
    @(posedge clk); #1;
    chk("rst_mid_b1", obs(0), 6'b110001);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", obs(0), 6'b000000);
    @(posedge clk); #1;
    chk("rst_held", obs(0), 6'b000000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_release", obs(0), 6'b000010);
    v[0] = 1'b1;
    d[0] = 4'b0001;
    check_word(0, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0000, "post_rst");
    @(posedge clk); #1;
    chk("post_rst_idle", obs(0), 6'b000010);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
`default_nettype wire
